// File: rtl/lab5_mcore_refill_arbiter_pkg.sv
// Shared lab5_mcore types: 16B memory request/response messages and the opaque-field
// requester ID tag (requester ID in opaque[7:6]).
package lab5_mcore_refill_arbiter_pkg;

    localparam int c_opaque_id_hi = 7;
    localparam int c_opaque_id_lo = 6;

    typedef logic [1:0] req_id_t;
    typedef logic [1:0] out_cnt_t;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    function automatic logic [7:0] set_opaque_id(input logic [7:0] opaque, input req_id_t id);
        logic [7:0] r;
        r = opaque;
        r[c_opaque_id_hi:c_opaque_id_lo] = id;
        return r;
    endfunction

    function automatic req_id_t get_opaque_id(input logic [7:0] opaque);
        return opaque[c_opaque_id_hi:c_opaque_id_lo];
    endfunction

endpackage

// File: rtl/lab5_mcore_refill_arbiter_if.sv
// Bundle of per-core icache refill ports plus the shared memory-network port.
// master = icaches and memory network side, slave = the refill arbiter.
interface lab5_mcore_refill_arbiter_if #(
    parameter int p_num_reqs = 4
);
    import lab5_mcore_refill_arbiter_pkg::*;

    mem_req_16B_t            req_msg [p_num_reqs];
    logic [p_num_reqs-1:0]   req_val;
    logic [p_num_reqs-1:0]   req_rdy;

    mem_resp_16B_t           resp_msg [p_num_reqs];
    logic [p_num_reqs-1:0]   resp_val;
    logic [p_num_reqs-1:0]   resp_rdy;

    mem_req_16B_t            memreq_msg;
    logic                    memreq_val;
    logic                    memreq_rdy;

    mem_resp_16B_t           memresp_msg;
    logic                    memresp_val;
    logic                    memresp_rdy;

    logic                    err;

    modport master (
        output req_msg, req_val, resp_rdy, memreq_rdy, memresp_msg, memresp_val,
        input  req_rdy, resp_msg, resp_val, memreq_msg, memreq_val, memresp_rdy, err
    );

    modport slave (
        input  req_msg, req_val, resp_rdy, memreq_rdy, memresp_msg, memresp_val,
        output req_rdy, resp_msg, resp_val, memreq_msg, memreq_val, memresp_rdy, err
    );

endinterface

// File: rtl/lab5_mcore_refill_resp_buffer.sv
// One-entry pipe queue for memory responses; 1-cycle enq-to-deq latency.
// enq_rdy stays high when full if the entry is leaving this cycle, so it sustains one per cycle.
module lab5_mcore_refill_resp_buffer
    import lab5_mcore_refill_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          enq_val,
    output logic          enq_rdy,
    input  mem_resp_16B_t enq_msg,
    output logic          deq_val,
    input  logic          deq_rdy,
    output mem_resp_16B_t deq_msg
);

    logic          full;
    mem_resp_16B_t entry;

    assign enq_rdy = !full || deq_rdy;
    assign deq_val = full;
    assign deq_msg = entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (enq_val && enq_rdy) begin
            full <= 1'b1;
        end else if (deq_rdy && full) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_val && enq_rdy) begin
            entry <= enq_msg;
        end
    end

endmodule

// File: rtl/lab5_mcore_refill_arbiter.sv
// Round-robin share of the imem network port among icache refills; requests 0-cycle, responses 1-cycle.
// A stalled grant is locked until it transfers; per-requester counters bound in-flight refills.
module lab5_mcore_refill_arbiter
    import lab5_mcore_refill_arbiter_pkg::*;
#(
    parameter int p_num_reqs = 4,
    parameter int p_max_out  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    lab5_mcore_refill_arbiter_if.slave    bus
);

    req_id_t               ptr;
    req_id_t               lock_id;
    logic                  lock;
    logic                  err_q;
    out_cnt_t              cnt [p_num_reqs];

    logic [p_num_reqs-1:0] elig;
    logic                  hi_found;
    req_id_t               hi_win;
    req_id_t               lo_win;
    req_id_t               gnt_id;
    logic                  gnt_elig;
    mem_req_16B_t          gnt_msg;
    logic                  xfer;
    req_id_t               next_ptr;

    req_id_t               resp_id;
    logic                  resp_id_ok;
    out_cnt_t              resp_id_cnt;
    logic                  stray;
    logic                  resp_acc;

    logic                  buf_enq_val;
    logic                  buf_enq_rdy;
    logic                  buf_deq_val;
    logic                  buf_deq_rdy;
    mem_resp_16B_t         buf_deq_msg;
    req_id_t               deq_id;
    mem_resp_16B_t         resp_out;
    logic [p_num_reqs-1:0] resp_val_w;

    always_comb begin
        for (int i = 0; i < p_num_reqs; i++) begin
            elig[i] = bus.req_val[i] && (int'(cnt[i]) < p_max_out);
        end
    end

    // Descending scan: lo_win ends on the lowest eligible index, hi_win on the lowest at or above ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = p_num_reqs - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_win = req_id_t'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_win   = req_id_t'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_id   = lock ? lock_id : (hi_found ? hi_win : lo_win);
        gnt_elig = 1'b0;
        gnt_msg  = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (req_id_t'(i) == gnt_id) begin
                gnt_elig = elig[i];
                gnt_msg  = bus.req_msg[i];
            end
        end
    end

    assign bus.memreq_val = !reset && gnt_elig;
    assign xfer           = bus.memreq_val && bus.memreq_rdy;
    assign next_ptr       = (int'(gnt_id) >= p_num_reqs - 1) ? '0 : gnt_id + 2'd1;

    always_comb begin
        bus.memreq_msg        = gnt_msg;
        bus.memreq_msg.opaque = set_opaque_id(gnt_msg.opaque, gnt_id);
    end

    always_comb begin
        for (int i = 0; i < p_num_reqs; i++) begin
            bus.req_rdy[i] = xfer && (req_id_t'(i) == gnt_id);
        end
    end

    assign resp_id = get_opaque_id(bus.memresp_msg.opaque);

    always_comb begin
        resp_id_ok  = 1'b0;
        resp_id_cnt = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (req_id_t'(i) == resp_id) begin
                resp_id_ok  = 1'b1;
                resp_id_cnt = cnt[i];
            end
        end
    end

    // Strays are still accepted so a bad tag cannot wedge the network; they just never enter the buffer.
    assign stray           = !resp_id_ok || (resp_id_cnt == '0);
    assign buf_enq_val     = bus.memresp_val && !stray;
    assign bus.memresp_rdy = buf_enq_rdy;
    assign resp_acc        = bus.memresp_val && bus.memresp_rdy;

    lab5_mcore_refill_resp_buffer u_resp_buffer (
        .clk     (clk),
        .reset   (reset),
        .enq_val (buf_enq_val),
        .enq_rdy (buf_enq_rdy),
        .enq_msg (bus.memresp_msg),
        .deq_val (buf_deq_val),
        .deq_rdy (buf_deq_rdy),
        .deq_msg (buf_deq_msg)
    );

    assign deq_id = get_opaque_id(buf_deq_msg.opaque);

    always_comb begin
        resp_out        = buf_deq_msg;
        resp_out.opaque = set_opaque_id(buf_deq_msg.opaque, '0);
    end

    always_comb begin
        buf_deq_rdy = 1'b0;
        resp_val_w  = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            bus.resp_msg[i] = resp_out;
            if (req_id_t'(i) == deq_id) begin
                resp_val_w[i] = buf_deq_val;
                buf_deq_rdy   = bus.resp_rdy[i];
            end
        end
    end

    assign bus.resp_val = resp_val_w;
    assign bus.err      = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
            err_q   <= 1'b0;
        end else begin
            lock    <= bus.memreq_val && !bus.memreq_rdy;
            lock_id <= gnt_id;
            if (xfer) begin
                ptr <= next_ptr;
            end
            if (resp_acc && stray) begin
                err_q <= 1'b1;
            end
        end
    end

    // Issue and retire on the same requester in one cycle cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_reqs; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else begin
                if (xfer && (req_id_t'(i) == gnt_id) &&
                    !(resp_acc && !stray && (req_id_t'(i) == resp_id))) begin
                    cnt[i] <= cnt[i] + 2'd1;
                end else if (resp_acc && !stray && (req_id_t'(i) == resp_id) &&
                             !(xfer && (req_id_t'(i) == gnt_id))) begin
                    cnt[i] <= cnt[i] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lab5_mcore_refill_arbiter.sv
// Directed bench for the refill arbiter: inputs change at negedge, outputs checked 1ns later.
module tb_lab5_mcore_refill_arbiter;
    import lab5_mcore_refill_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    lab5_mcore_refill_arbiter_if #(.p_num_reqs(4)) bus ();

    lab5_mcore_refill_arbiter #(.p_num_reqs(4), .p_max_out(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.req_val     = '0;
        bus.resp_rdy    = '1;
        bus.memreq_rdy  = 1'b1;
        bus.memresp_val = 1'b0;
        bus.memresp_msg = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_msg[i]        = '0;
            bus.req_msg[i].addr   = 32'((i + 1) * 256);
            bus.req_msg[i].opaque = {2'b11, 6'(i)};
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (bus.memreq_val !== 1'b0) begin n_fail++; $display("FAIL rst_memreq_val: got %b want 0", bus.memreq_val); end
        n_cmp++; if (bus.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL rst_req_rdy: got %b want 0000", bus.req_rdy); end
        n_cmp++; if (bus.resp_val !== 4'b0000) begin n_fail++; $display("FAIL rst_resp_val: got %b want 0000", bus.resp_val); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_memresp_rdy: got %b want 1", bus.memresp_rdy); end
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.req_val     = 4'b1111;
            bus.memresp_val = (k == 1);
            bus.memresp_msg = '0;
            #1;
            w = k % 4;
            n_cmp++; if (bus.memreq_val !== 1'b1) begin n_fail++; $display("FAIL rr_val c%0d: got %b want 1", k, bus.memreq_val); end
            n_cmp++; if (bus.memreq_msg.addr !== 32'((w + 1) * 256)) begin n_fail++; $display("FAIL rr_addr c%0d: got %h want %h", k, bus.memreq_msg.addr, 32'((w + 1) * 256)); end
            n_cmp++; if (bus.memreq_msg.opaque !== {2'(w), 6'(w)}) begin n_fail++; $display("FAIL rr_opaque c%0d: got %h want %h", k, bus.memreq_msg.opaque, {2'(w), 6'(w)}); end
            n_cmp++; if (bus.req_rdy !== 4'(1 << w)) begin n_fail++; $display("FAIL rr_req_rdy c%0d: got %b want %b", k, bus.req_rdy, 4'(1 << w)); end
            if (k == 2) begin
                n_cmp++; if (bus.resp_val !== 4'b0001) begin n_fail++; $display("FAIL rr_resp_val: got %b want 0001", bus.resp_val); end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        bus.req_val = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            if (k >= 1) bus.req_val = 4'b0110;
            bus.memreq_rdy = (k == 3);
            #1;
            n_cmp++; if (bus.memreq_val !== 1'b1) begin n_fail++; $display("FAIL lock_val c%0d: got %b want 1", k, bus.memreq_val); end
            n_cmp++; if (bus.memreq_msg.addr !== 32'h300) begin n_fail++; $display("FAIL lock_addr c%0d: got %h want 300", k, bus.memreq_msg.addr); end
            n_cmp++; if (bus.memreq_msg.opaque !== 8'h82) begin n_fail++; $display("FAIL lock_opaque c%0d: got %h want 82", k, bus.memreq_msg.opaque); end
            n_cmp++; if (bus.req_rdy !== ((k == 3) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL lock_req_rdy c%0d: got %b", k, bus.req_rdy); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (bus.memreq_msg.addr !== 32'h200) begin n_fail++; $display("FAIL lock_next_addr: got %h want 200", bus.memreq_msg.addr); end
        n_cmp++; if (bus.req_rdy !== 4'b0010) begin n_fail++; $display("FAIL lock_next_rdy: got %b want 0010", bus.req_rdy); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_max_out();
        do_reset();
        bus.req_msg[0].addr = 32'h1000;
        bus.req_val = 4'b0001;
        #1;
        n_cmp++; if (bus.memreq_msg.addr !== 32'h1000 || bus.memreq_val !== 1'b1) begin n_fail++; $display("FAIL mo_first: got val=%b addr=%h want 1/1000", bus.memreq_val, bus.memreq_msg.addr); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.memreq_val !== 1'b0) begin n_fail++; $display("FAIL mo_block_c1: got %b want 0", bus.memreq_val); end
        n_cmp++; if (bus.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL mo_rdy_c1: got %b want 0000", bus.req_rdy); end
        @(negedge clk);
        bus.memresp_val        = 1'b1;
        bus.memresp_msg.opaque = 8'h05;
        bus.memresp_msg.data   = {4{32'hDEADBEEF}};
        #1;
        n_cmp++; if (bus.memreq_val !== 1'b0) begin n_fail++; $display("FAIL mo_block_c2: got %b want 0", bus.memreq_val); end
        n_cmp++; if (bus.memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL mo_memresp_rdy: got %b want 1", bus.memresp_rdy); end
        @(negedge clk);
        bus.memresp_val = 1'b0;
        #1;
        n_cmp++; if (bus.resp_val !== 4'b0001) begin n_fail++; $display("FAIL mo_resp_val: got %b want 0001", bus.resp_val); end
        n_cmp++; if (bus.resp_msg[0].opaque !== 8'h05) begin n_fail++; $display("FAIL mo_resp_opaque: got %h want 05", bus.resp_msg[0].opaque); end
        n_cmp++; if (bus.resp_msg[0].data !== {4{32'hDEADBEEF}}) begin n_fail++; $display("FAIL mo_resp_data: got %h", bus.resp_msg[0].data); end
        n_cmp++; if (bus.memreq_val !== 1'b1) begin n_fail++; $display("FAIL mo_regrant: got %b want 1", bus.memreq_val); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_resp_backpressure();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h100; exp_addr[1] = 32'h300; exp_addr[2] = 32'h400;
        do_reset();
        bus.req_val = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.memreq_msg.addr !== exp_addr[k]) begin n_fail++; $display("FAIL bp_grant c%0d: got %h want %h", k, bus.memreq_msg.addr, exp_addr[k]); end
            @(negedge clk);
        end
        bus.req_val            = 4'b0000;
        bus.resp_rdy           = 4'b0111;
        bus.memresp_val        = 1'b1;
        bus.memresp_msg.opaque = 8'hC3;
        #1;
        n_cmp++; if (bus.memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_accept_c3: got %b want 1", bus.memresp_rdy); end
        @(negedge clk);
        bus.memresp_msg.opaque = 8'h01;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (bus.resp_val !== 4'b1000) begin n_fail++; $display("FAIL bp_hold_val c%0d: got %b want 1000", k, bus.resp_val); end
            n_cmp++; if (bus.resp_msg[3].opaque !== 8'h03) begin n_fail++; $display("FAIL bp_hold_opaque c%0d: got %h want 03", k, bus.resp_msg[3].opaque); end
            n_cmp++; if (bus.memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_hold_rdy c%0d: got %b want 0", k, bus.memresp_rdy); end
            @(negedge clk);
        end
        bus.resp_rdy = 4'b1111;
        #1;
        n_cmp++; if (bus.memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_pipe_rdy: got %b want 1", bus.memresp_rdy); end
        @(negedge clk);
        bus.memresp_msg.opaque = 8'h82;
        bus.memresp_msg.data   = 128'h1234;
        #1;
        n_cmp++; if (bus.resp_val !== 4'b0001) begin n_fail++; $display("FAIL bp_b2b_val0: got %b want 0001", bus.resp_val); end
        n_cmp++; if (bus.resp_msg[0].opaque !== 8'h01) begin n_fail++; $display("FAIL bp_b2b_op0: got %h want 01", bus.resp_msg[0].opaque); end
        n_cmp++; if (bus.memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_rdy: got %b want 1", bus.memresp_rdy); end
        @(negedge clk);
        bus.memresp_val = 1'b0;
        #1;
        n_cmp++; if (bus.resp_val !== 4'b0100) begin n_fail++; $display("FAIL bp_b2b_val2: got %b want 0100", bus.resp_val); end
        n_cmp++; if (bus.resp_msg[2].opaque !== 8'h02 || bus.resp_msg[2].data !== 128'h1234) begin n_fail++; $display("FAIL bp_b2b_msg2: got %h/%h want 02/1234", bus.resp_msg[2].opaque, bus.resp_msg[2].data); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.resp_val !== 4'b0000) begin n_fail++; $display("FAIL bp_drained: got %b want 0000", bus.resp_val); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b want 0", bus.err); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_stray();
        do_reset();
        bus.memresp_val        = 1'b1;
        bus.memresp_msg.opaque = 8'h40;
        #1;
        n_cmp++; if (bus.memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL stray_rdy: got %b want 1", bus.memresp_rdy); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL stray_err_before: got %b want 0", bus.err); end
        @(negedge clk);
        bus.memresp_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL stray_err c%0d: got %b want 1", k, bus.err); end
            n_cmp++; if (bus.resp_val !== 4'b0000) begin n_fail++; $display("FAIL stray_dropped c%0d: got %b want 0000", k, bus.resp_val); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.req_val            = 4'b0001;
        bus.memresp_val        = 1'b1;
        bus.memresp_msg.opaque = 8'h80;
        #1;
        n_cmp++; if (bus.memreq_val !== 1'b1) begin n_fail++; $display("FAIL mid_c0_val: got %b want 1", bus.memreq_val); end
        @(negedge clk);
        bus.req_val            = 4'b0010;
        bus.memreq_rdy         = 1'b0;
        bus.memresp_msg.opaque = 8'h00;
        bus.resp_rdy           = 4'b1110;
        #1;
        n_cmp++; if (bus.memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_c1_rdy: got %b want 1", bus.memresp_rdy); end
        @(negedge clk);
        bus.memresp_val = 1'b0;
        #1;
        n_cmp++; if (bus.err !== 1'b1 || bus.resp_val !== 4'b0001) begin n_fail++; $display("FAIL mid_c2_state: got err=%b resp_val=%b want 1/0001", bus.err, bus.resp_val); end
        n_cmp++; if (bus.memreq_val !== 1'b1 || bus.memreq_msg.addr !== 32'h200) begin n_fail++; $display("FAIL mid_c2_lock: got val=%b addr=%h want 1/200", bus.memreq_val, bus.memreq_msg.addr); end
        reset       = 1'b1;
        bus.req_val = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.memreq_val !== 1'b0 || bus.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL mid_req_cleared: got val=%b rdy=%b want 0/0000", bus.memreq_val, bus.req_rdy); end
        n_cmp++; if (bus.resp_val !== 4'b0000) begin n_fail++; $display("FAIL mid_resp_cleared: got %b want 0000", bus.resp_val); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL mid_err_cleared: got %b want 0", bus.err); end
        n_cmp++; if (bus.memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_memresp_rdy: got %b want 1", bus.memresp_rdy); end
        @(negedge clk);
        bus.req_val    = 4'b0011;
        bus.memreq_rdy = 1'b1;
        #1;
        n_cmp++; if (bus.memreq_msg.addr !== 32'h100 || bus.req_rdy !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_zero: got addr=%h rdy=%b want 100/0001", bus.memreq_msg.addr, bus.req_rdy); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin();
        test_lock();
        test_max_out();
        test_resp_backpressure();
        test_stray();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
